// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: the parity-check matrix, message-bit column weights and decoder states.
package ldpc_pkg;

  localparam int unsigned N_MSG  = 8;
  localparam int unsigned N_CHK  = 8;
  localparam int unsigned N_BITS = 16;

  // Row j is check s_j over the working word: bits [15:8] are m7..m0, bit j is p_j.
  localparam logic [N_CHK-1:0][N_BITS-1:0] H_MATRIX = {
    16'hAC80,  // s7: m7 m5 m3 m2 p7
    16'h6640,  // s6: m6 m5 m2 m1 p6
    16'hB220,  // s5: m7 m5 m4 m1 p5
    16'h5910,  // s4: m6 m4 m3 m0 p4
    16'hB508,  // s3: m7 m5 m4 m2 m0 p3
    16'h4F04,  // s2: m6 m3 m2 m1 m0 p2
    16'h9B02,  // s1: m7 m4 m3 m1 m0 p1
    16'h7301   // s0: m6 m5 m4 m1 m0 p0
  };

  // Number of checks each message bit participates in (column weight), index i = m_i.
  localparam logic [N_MSG-1:0][2:0] MSG_DEGREE = {
    3'd4, 3'd4, 3'd5, 3'd5, 3'd4, 3'd4, 3'd5, 3'd5
  };

  // Below this many unsatisfied checks a message bit is not trusted to be the error.
  localparam logic [2:0] FLIP_THRESH = 3'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

endpackage

// File: rtl/ldpc_syndrome.sv
// Combinational syndrome of a 16-bit working word against the shared parity-check matrix.
module ldpc_syndrome
  import ldpc_pkg::*;
(
  input  logic [N_BITS-1:0] i_word,
  output logic [N_CHK-1:0]  o_syn
);

  // Each syndrome bit is the parity of the word masked by its matrix row.
  always_comb begin
    o_syn = '0;
    for (int j = 0; j < N_CHK; j++) begin
      o_syn[j] = ^(i_word & H_MATRIX[j]);
    end
  end

endmodule

// File: rtl/ldpc_decoder.sv
// Iterative bit-flip decoder for the (16,8) LDPC code, one codeword in flight at a time.
module ldpc_decoder
  import ldpc_pkg::*;
#(
  parameter int unsigned MAX_ITER = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] cw,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  m_out,
  output logic        dec_ok,
  output logic [3:0]  iter_cnt
);

  localparam logic [3:0] ITER_LIMIT = 4'(MAX_ITER);

  state_e      r_state;
  logic [15:0] r_word;
  logic [3:0]  r_iter;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [7:0]  r_m_out;
  logic        r_dec_ok;
  logic [3:0]  r_iter_cnt;

  logic [N_CHK-1:0]      w_syn;
  logic [N_MSG-1:0][2:0] w_sat;
  logic [N_MSG-1:0][2:0] w_unsat;
  logic [2:0]            w_umax;
  logic [N_MSG-1:0]      w_msg_flip;
  logic [15:0]           w_word_next;

  ldpc_syndrome u_syndrome (
    .i_word (r_word),
    .o_syn  (w_syn)
  );

  // Unsatisfied checks per message bit, as column weight minus satisfied checks on that column.
  always_comb begin
    w_sat   = '0;
    w_unsat = '0;
    for (int i = 0; i < N_MSG; i++) begin
      for (int j = 0; j < N_CHK; j++) begin
        if (H_MATRIX[j][N_CHK + i] && !w_syn[j]) begin
          w_sat[i] = w_sat[i] + 3'd1;
        end
      end
      w_unsat[i] = MSG_DEGREE[i] - w_sat[i];
    end
  end

  // Flip decision: strongly-implicated message bits, else the parity bits of failing checks.
  always_comb begin
    w_umax     = '0;
    w_msg_flip = '0;
    for (int i = 0; i < N_MSG; i++) begin
      if (w_unsat[i] > w_umax) begin
        w_umax = w_unsat[i];
      end
    end
    for (int i = 0; i < N_MSG; i++) begin
      w_msg_flip[i] = (w_unsat[i] == w_umax);
    end
    if (w_umax >= FLIP_THRESH) begin
      w_word_next = r_word ^ {w_msg_flip, 8'h00};
    end else begin
      w_word_next = r_word ^ {8'h00, w_syn};
    end
  end

  // Control FSM; handshake flags and result fields are registered so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_word      <= '0;
      r_iter      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_m_out     <= '0;
      r_dec_ok    <= 1'b0;
      r_iter_cnt  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_word     <= cw;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= StIter;
          end
        end
        StIter: begin
          if (w_syn == '0) begin
            r_m_out     <= r_word[15:8];
            r_dec_ok    <= 1'b1;
            r_iter_cnt  <= r_iter;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else if (r_iter == ITER_LIMIT) begin
            r_m_out     <= r_word[15:8];
            r_dec_ok    <= 1'b0;
            r_iter_cnt  <= r_iter;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_word <= w_word_next;
            r_iter <= r_iter + 4'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign m_out     = r_m_out;
  assign dec_ok    = r_dec_ok;
  assign iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_ldpc_decoder.sv
// Scoreboard bench for ldpc_decoder: a behavioural bit-flip model predicts each result.
module tb_ldpc_decoder;

  localparam int MAX_ITER = 4;

  typedef struct {
    logic [7:0] m;
    logic       ok;
    logic [3:0] it;
    int         lat;
  } exp_t;

  typedef struct {
    logic [7:0] m;
    logic       ok;
    logic [3:0] it;
    int         lat;
    logic       to;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] cw = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  m_out;
  logic        dec_ok;
  logic [3:0]  iter_cnt;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hs_cyc = 0;

  ldpc_decoder #(
    .MAX_ITER (MAX_ITER)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cw        (cw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m_out     (m_out),
    .dec_ok    (dec_ok),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_syn(input logic [15:0] w);
    logic [7:0] m;
    logic [7:0] p;
    logic [7:0] s;
    m = w[15:8];
    p = w[7:0];
    s[7] = p[7] ^ m[7] ^ m[5] ^ m[3] ^ m[2];
    s[6] = p[6] ^ m[6] ^ m[5] ^ m[2] ^ m[1];
    s[5] = p[5] ^ m[7] ^ m[5] ^ m[4] ^ m[1];
    s[4] = p[4] ^ m[6] ^ m[4] ^ m[3] ^ m[0];
    s[3] = p[3] ^ m[7] ^ m[5] ^ m[4] ^ m[2] ^ m[0];
    s[2] = p[2] ^ m[6] ^ m[3] ^ m[2] ^ m[1] ^ m[0];
    s[1] = p[1] ^ m[7] ^ m[4] ^ m[3] ^ m[1] ^ m[0];
    s[0] = p[0] ^ m[6] ^ m[5] ^ m[4] ^ m[1] ^ m[0];
    return s;
  endfunction

  // Behavioural decode; a message bit's checks are found by toggling it and diffing syndromes.
  function automatic exp_t ref_decode(input logic [15:0] word);
    exp_t        e;
    logic [15:0] w;
    logic [15:0] bit_i;
    logic [7:0]  s;
    logic [7:0]  d;
    int          u[8];
    int          umax;
    int          n;
    w = word;
    n = 0;
    e.ok = 1'b0;
    for (int k = 0; k <= MAX_ITER + 1; k++) begin
      s = ref_syn(w);
      if (s == 8'h00) begin
        e.ok = 1'b1;
        break;
      end
      if (n == MAX_ITER) begin
        e.ok = 1'b0;
        break;
      end
      umax = 0;
      for (int i = 0; i < 8; i++) begin
        bit_i = 16'h0100 << i;
        d = ref_syn(w ^ bit_i) ^ s;
        u[i] = $countones(s & d);
        if (u[i] > umax) umax = u[i];
      end
      if (umax >= 3) begin
        for (int i = 0; i < 8; i++) begin
          bit_i = 16'h0100 << i;
          if (u[i] == umax) w = w ^ bit_i;
        end
      end else begin
        w = w ^ {8'h00, s};
      end
      n++;
    end
    e.m   = w[15:8];
    e.it  = 4'(n);
    e.lat = n + 2;
    return e;
  endfunction

  task automatic drive(input logic [15:0] word);
    for (int k = 0; k < 50 && !in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    sb.push_back(ref_decode(word));
    in_valid = 1'b1;
    cw       = word;
    hs_cyc   = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output obs_t o);
    o.to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        o.to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    o.m   = m_out;
    o.ok  = dec_ok;
    o.it  = iter_cnt;
    o.lat = cyc - hs_cyc;
  endtask

  task automatic pop_exp(output exp_t e);
    e.m   = 8'hxx;
    e.ok  = 1'bx;
    e.it  = 4'hx;
    e.lat = -1;
    if (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic collect(output obs_t o, output exp_t e);
    wait_out(o);
    pop_exp(e);
    if (!o.to) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (m_out !== 8'h00) begin errors++; $display("FAIL reset_m_out got %h want 00", m_out); end
    checks++; if (dec_ok !== 1'b0) begin errors++; $display("FAIL reset_dec_ok got %b want 0", dec_ok); end
    checks++; if (iter_cnt !== 4'd0) begin errors++; $display("FAIL reset_iter_cnt got %0d want 0", iter_cnt); end
  endtask

  task automatic test_clean;
    logic [15:0] words[2];
    obs_t o;
    exp_t e;
    words[0] = 16'hA590;
    words[1] = 16'h0000;
    for (int n = 0; n < 2; n++) begin
      drive(words[n]);
      collect(o, e);
      checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL clean_timeout cw=%h no out_valid", words[n]); end
      checks++; if (o.m !== e.m) begin errors++; $display("FAIL clean_m cw=%h got %h want %h", words[n], o.m, e.m); end
      checks++; if (o.ok !== e.ok || o.ok !== 1'b1) begin errors++; $display("FAIL clean_ok cw=%h got %b want 1", words[n], o.ok); end
      checks++; if (o.it !== 4'd0) begin errors++; $display("FAIL clean_iter cw=%h got %0d want 0", words[n], o.it); end
      checks++; if (o.lat != 2) begin errors++; $display("FAIL clean_latency cw=%h got %0d want 2", words[n], o.lat); end
    end
  endtask

  task automatic test_single_errors;
    logic [15:0] word;
    obs_t o;
    exp_t e;
    for (int b = -2; b < 16; b++) begin
      // Two named vectors first (m5 and p4 flipped), then every single-bit error on 0xA590.
      if (b == -2) word = 16'h8590;
      else if (b == -1) word = 16'hA580;
      else word = 16'hA590 ^ (16'h0001 << b);
      drive(word);
      collect(o, e);
      checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL single_timeout cw=%h no out_valid", word); end
      checks++; if (o.m !== 8'hA5 || o.m !== e.m) begin errors++; $display("FAIL single_m cw=%h got %h want a5", word, o.m); end
      checks++; if (o.ok !== 1'b1) begin errors++; $display("FAIL single_ok cw=%h got %b want 1", word, o.ok); end
      checks++; if (o.it !== 4'd1) begin errors++; $display("FAIL single_iter cw=%h got %0d want 1", word, o.it); end
      checks++; if (o.lat != 3) begin errors++; $display("FAIL single_latency cw=%h got %0d want 3", word, o.lat); end
    end
  endtask

  task automatic test_double;
    logic [15:0] words[2];
    obs_t o;
    exp_t e;
    words[0] = 16'h2590;
    words[1] = 16'h6590;
    for (int n = 0; n < 2; n++) begin
      drive(words[n]);
      collect(o, e);
      checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL double_timeout cw=%h no out_valid", words[n]); end
      checks++; if (o.m !== e.m) begin errors++; $display("FAIL double_m cw=%h got %h want %h", words[n], o.m, e.m); end
      checks++; if (o.ok !== e.ok) begin errors++; $display("FAIL double_ok cw=%h got %b want %b", words[n], o.ok, e.ok); end
      checks++; if (o.it !== e.it || o.it > 4'(MAX_ITER)) begin errors++; $display("FAIL double_iter cw=%h got %0d want %0d", words[n], o.it, e.it); end
      checks++; if (o.lat != e.lat || o.lat > MAX_ITER + 2) begin errors++; $display("FAIL double_latency cw=%h got %0d want %0d", words[n], o.lat, e.lat); end
    end
  endtask

  task automatic test_backpressure;
    obs_t o;
    exp_t e;
    drive(16'hA590);
    wait_out(o);
    pop_exp(e);
    checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL bp_first_timeout no out_valid"); end
    checks++; if (o.m !== e.m) begin errors++; $display("FAIL bp_first_m got %h want %h", o.m, e.m); end
    // Offer the second codeword while the first result is stalled.
    in_valid = 1'b1;
    cw       = 16'h8590;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || m_out !== e.m || dec_ok !== e.ok || iter_cnt !== e.it || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b m=%h ok=%b it=%0d rdy=%b want v=1 m=%h ok=%b it=%0d rdy=0",
                 k, out_valid, m_out, dec_ok, iter_cnt, in_ready, e.m, e.ok, e.it);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_drop got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after got %b want 1", in_ready); end
    sb.push_back(ref_decode(16'h8590));
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    collect(o, e);
    checks++; if (o.to !== 1'b0) begin errors++; $display("FAIL bp_second_timeout no out_valid"); end
    checks++; if (o.m !== e.m || o.it !== e.it || o.ok !== e.ok) begin errors++; $display("FAIL bp_second got m=%h it=%0d ok=%b want m=%h it=%0d ok=%b", o.m, o.it, o.ok, e.m, e.it, e.ok); end
    checks++; if (o.lat != e.lat) begin errors++; $display("FAIL bp_second_latency got %0d want %0d", o.lat, e.lat); end
  endtask

  task automatic test_reset_mid_iter;
    exp_t e;
    logic seen;
    drive(16'h8590);
    pop_exp(e);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
    checks++; if (m_out !== 8'h00 || dec_ok !== 1'b0 || iter_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_outputs got m=%h ok=%b it=%0d want 00 0 0", m_out, dec_ok, iter_cnt); end
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_output got out_valid=1 want none"); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] word;
    obs_t o;
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      if (n % 2 == 0) word = 16'($urandom);
      else word = 16'hA590 ^ (16'h0001 << $urandom_range(15, 0)) ^ (16'h0001 << $urandom_range(15, 0));
      drive(word);
      collect(o, e);
      checks++;
      if (o.to !== 1'b0 || o.m !== e.m || o.ok !== e.ok || o.it !== e.it || o.lat != e.lat) begin
        errors++;
        $display("FAIL b2b cw=%h got to=%b m=%h ok=%b it=%0d lat=%0d want m=%h ok=%b it=%0d lat=%0d",
                 word, o.to, o.m, o.ok, o.it, o.lat, e.m, e.ok, e.it, e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_errors();
    test_double();
    test_backpressure();
    test_reset_mid_iter();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
